// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Transmit-path sequencer between the downstream FWFT FIFO and the TX
// serializer. Frames are popped from the FIFO head and handed to the
// serializer over a valid/ready handshake. Hardware flow control (CTS) and an
// enable gate hold back new frames. After the serializer reports the stop bit,
// a programmable inter-frame gap is inserted. Entries flagged with a parity
// error are dropped, and a level flush drains the FIFO while nothing is in
// flight. Completion, drop and CTS-timeout events are single-cycle pulses for
// the IRQ generator. Busy and frame-count status go to the register map.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_enable               transmitter enable
//   i_hw_flow_en, i_cts    flow-control enable and synchronized clear-to-send
//   i_flush                drain the FIFO while IDLE / WAIT_CTS (level)
//   i_gap_cycles           idle cycles inserted after each frame
//   i_fifo_*               FWFT FIFO head (valid, data, parity error)
//   o_fifo_rd_req          pop the FIFO head, one pulse per entry
//   o_tx_valid, o_tx_data  byte offered to the serializer
//   i_tx_ready, i_tx_done  serializer accept and end-of-frame pulse
//   o_tx_done              pulse per completed frame
//   o_drop                 pulse per entry discarded for a parity error
//   o_cts_timeout          pulse each time CTS has been low for CTS_TIMEOUT cycles
//   o_busy                 state is not IDLE
//   o_frame_cnt            frames sent, wraps
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int GAP_WIDTH   = 8,
    parameter int CTS_TIMEOUT = 65535,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_hw_flow_en,
    input  logic                  i_cts,
    input  logic                  i_flush,
    input  logic [GAP_WIDTH-1:0]  i_gap_cycles,
    input  logic                  i_fifo_valid,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_parity_error,
    output logic                  o_fifo_rd_req,
    output logic                  o_tx_valid,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_ready,
    input  logic                  i_tx_done,
    output logic                  o_tx_done,
    output logic                  o_drop,
    output logic                  o_cts_timeout,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_CTS  = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // The timeout counter only has to reach CTS_TIMEOUT-1.
    localparam int TO_WIDTH = (CTS_TIMEOUT > 1) ? $clog2(CTS_TIMEOUT) : 1;
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        (CTS_TIMEOUT > 0) ? TO_WIDTH'(CTS_TIMEOUT - 1) : '0;
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

    logic [2:0]            state_q,       state_d;
    logic [DATA_WIDTH-1:0] tx_data_q,     tx_data_d;
    logic                  tx_valid_q,    tx_valid_d;
    logic                  tx_done_q,     tx_done_d;
    logic                  drop_q,        drop_d;
    logic                  cts_timeout_q, cts_timeout_d;
    logic                  busy_q,        busy_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q,   frame_cnt_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q,     gap_cnt_d;
    logic [TO_WIDTH-1:0]   cts_cnt_q,     cts_cnt_d;
    logic                  fifo_pop;

    // Next-state and datapath logic.
    // The FIFO pop is combinational so that the head is consumed in the same
    // cycle in which the decision is made. The FWFT FIFO then presents the
    // next entry in the following cycle. This lets a flush drain one entry per
    // cycle.
    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        frame_cnt_d   = frame_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        cts_cnt_d     = '0;
        fifo_pop      = 1'b0;
        drop_d        = 1'b0;
        tx_done_d     = 1'b0;
        cts_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A flush outranks everything and pops even when the
                // transmitter is disabled.
                if (i_flush && i_fifo_valid) begin
                    fifo_pop = 1'b1;
                end else if (i_enable && i_fifo_valid) begin
                    if (i_fifo_parity_error) begin
                        fifo_pop = 1'b1;
                        drop_d   = 1'b1;
                    end else if (i_hw_flow_en && !i_cts) begin
                        // Leave the byte in the FIFO. It is re-evaluated here
                        // once CTS returns.
                        state_d = ST_WAIT_CTS;
                    end else begin
                        fifo_pop  = 1'b1;
                        tx_data_d = i_fifo_data;
                        state_d   = ST_SEND;
                    end
                end
            end

            ST_WAIT_CTS: begin
                // Every exit goes through IDLE so that the full priority
                // decode (flush, parity, CTS) runs again on the head entry.
                if (i_cts || !i_enable || !i_hw_flow_en || i_flush) begin
                    state_d = ST_IDLE;
                end else if (CTS_TIMEOUT != 0) begin
                    if (cts_cnt_q == TO_LAST) begin
                        cts_timeout_d = 1'b1;
                    end else begin
                        cts_cnt_d = cts_cnt_q + 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (i_tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    tx_done_d   = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    if (i_gap_cycles != '0) begin
                        gap_cnt_d = i_gap_cycles;
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                // The counter holds the number of GAP cycles still to spend,
                // including the current one.
                if (gap_cnt_q <= GAP_ONE) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Valid and busy are registered decodes of the state being entered.
        // They therefore line up exactly with the state register.
        tx_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers.
    // A reset abandons any frame in flight immediately.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_done_q     <= 1'b0;
            drop_q        <= 1'b0;
            cts_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            cts_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_done_q     <= tx_done_d;
            drop_q        <= drop_d;
            cts_timeout_q <= cts_timeout_d;
            busy_q        <= busy_d;
            frame_cnt_q   <= frame_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            cts_cnt_q     <= cts_cnt_d;
        end
    end

    assign o_fifo_rd_req = fifo_pop;
    assign o_tx_valid    = tx_valid_q;
    assign o_tx_data     = tx_data_q;
    assign o_tx_done     = tx_done_q;
    assign o_drop        = drop_q;
    assign o_cts_timeout = cts_timeout_q;
    assign o_busy        = busy_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule
